// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header extraction path.
package axis_hdr_pkg;

  localparam int MAX_BYTE_WD = 128;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    FLUSH
  } state_t;

  function automatic int count_ones(input logic [MAX_BYTE_WD-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTE_WD; i++) begin
      if (keep[i]) c++;
    end
    return c;
  endfunction

  // Sets the n most significant bits of a width-bit field; callers truncate to width.
  function automatic logic [MAX_BYTE_WD-1:0] msb_mask(input int n, input int width);
    logic [MAX_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTE_WD; i++) begin
      m[i] = (i < width) && (i >= width - n);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_byte_realign.sv
// Combinational byte shifter: splits an incoming beat at the header boundary and
// merges its top bytes behind the MSB-aligned residual.
module axi_stream_byte_realign #(
  parameter int DATA_WD = 32,
  parameter int CNT_WD  = 3
) (
  input  logic [DATA_WD-1:0] resid_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [CNT_WD-1:0]  hdr_bytes,
  output logic [DATA_WD-1:0] aligned_out,
  output logic [DATA_WD-1:0] merged_out,
  output logic [DATA_WD-1:0] resid_out
);

  localparam int BYTE_WD = DATA_WD / 8;

  int n_bits;
  int r_bits;

  // A shift by the full width yields zero, which covers the N=DATA_BYTE_WD case.
  always_comb begin
    n_bits      = 8 * int'(hdr_bytes);
    r_bits      = 8 * (BYTE_WD - int'(hdr_bytes));
    aligned_out = data_in >> r_bits;
    merged_out  = resid_in | aligned_out;
    resid_out   = data_in << n_bits;
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// AXI-Stream header extractor: strips an N-byte header from the first beat onto a
// side channel and repacks the remaining payload into fully packed beats.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;

  state_t                  state_q, state_d;
  logic [CNT_WD-1:0]       hdr_bytes_q, hdr_bytes_d, hdr_bytes_cur;
  logic [CNT_WD-1:0]       flush_cnt_q, flush_cnt_d;
  logic [DATA_WD-1:0]      resid_q, resid_d;
  logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

  logic [DATA_WD-1:0]      data_masked, aligned, merged, resid_next;
  logic                    out_free;
  int                      n_int, r_int, k_int;

  // Lanes outside keep are zeroed up front so every downstream path emits clean bytes.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      data_masked[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
    end
    hdr_bytes_cur = (state_q == IDLE) ? (CNT_WD'(byte_remove_cnt) + CNT_WD'(1)) : hdr_bytes_q;
  end

  axi_stream_byte_realign #(
    .DATA_WD(DATA_WD),
    .CNT_WD (CNT_WD)
  ) u_realign (
    .resid_in   (resid_q),
    .data_in    (data_masked),
    .hdr_bytes  (hdr_bytes_cur),
    .aligned_out(aligned),
    .merged_out (merged),
    .resid_out  (resid_next)
  );

  always_comb begin
    state_d     = state_q;
    hdr_bytes_d = hdr_bytes_q;
    flush_cnt_d = flush_cnt_q;
    resid_d     = resid_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    valid_hdr_d = valid_hdr_q && !ready_hdr;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    ready_in    = 1'b0;
    out_free    = !valid_out_q || ready_out;
    n_int       = int'(hdr_bytes_cur);
    r_int       = DATA_BYTE_WD - n_int;
    k_int       = count_ones(MAX_BYTE_WD'(keep_in));

    case (state_q)
      IDLE: begin
        ready_in = !valid_hdr_q && out_free;
        if (valid_in && ready_in) begin
          hdr_bytes_d = hdr_bytes_cur;
          valid_hdr_d = 1'b1;
          data_hdr_d  = aligned;
          keep_hdr_d  = {DATA_BYTE_WD{1'b1}} >> r_int;
          resid_d     = resid_next;
          if (!last_in) begin
            state_d = BODY;
          end else if (k_int > n_int) begin
            valid_out_d = 1'b1;
            data_out_d  = resid_next;
            keep_out_d  = DATA_BYTE_WD'(msb_mask(k_int - n_int, DATA_BYTE_WD));
            last_out_d  = 1'b1;
          end
        end
      end
      BODY: begin
        ready_in = out_free;
        if (valid_in && ready_in) begin
          valid_out_d = 1'b1;
          data_out_d  = merged;
          resid_d     = resid_next;
          keep_out_d  = {DATA_BYTE_WD{1'b1}};
          last_out_d  = 1'b0;
          if (last_in) begin
            if (r_int + k_int <= DATA_BYTE_WD) begin
              keep_out_d = DATA_BYTE_WD'(msb_mask(r_int + k_int, DATA_BYTE_WD));
              last_out_d = 1'b1;
              state_d    = IDLE;
            end else begin
              flush_cnt_d = CNT_WD'(r_int + k_int - DATA_BYTE_WD);
              state_d     = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          valid_out_d = 1'b1;
          data_out_d  = resid_q;
          keep_out_d  = DATA_BYTE_WD'(msb_mask(int'(flush_cnt_q), DATA_BYTE_WD));
          last_out_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_bytes_q <= '0;
      flush_cnt_q <= '0;
      resid_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      valid_hdr_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_bytes_q <= hdr_bytes_d;
      flush_cnt_q <= flush_cnt_d;
      resid_q     <= resid_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      valid_hdr_q <= valid_hdr_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign valid_hdr = valid_hdr_q;
  assign data_hdr  = data_hdr_q;
  assign keep_hdr  = keep_hdr_q;

endmodule
